// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit. Turns one core request into a word-aligned bus transaction with byte enables.
// Optional MREQ/MWAIT abort counter is compiled in with `define LSU_TIMEOUT_EN.
module rv_lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MREQ  = 3'd2,
    S_MWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;

  logic        legal_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s;
  logic [31:0] lane_s;
  logic [31:0] ld_data_s;
  logic        tmo_hit_s;

  // Width decode of the captured request: legality, byte enables and lane-replicated store data.
  always_comb begin
    legal_s     = 1'b0;
    be_s        = 4'b0000;
    wdata_rep_s = 32'h0000_0000;
    case (funct3_r[1:0])
      2'b00: begin
        legal_s     = !(we_r && funct3_r[2]);
        be_s        = 4'b0001 << addr_r[1:0];
        wdata_rep_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        legal_s     = !addr_r[0] && !(we_r && funct3_r[2]);
        be_s        = 4'b0011 << addr_r[1:0];
        wdata_rep_s = {2{wdata_r[15:0]}};
      end
      2'b10: begin
        legal_s     = (addr_r[1:0] == 2'b00) && !funct3_r[2];
        be_s        = 4'b1111;
        wdata_rep_s = wdata_r;
      end
      default: begin
        legal_s     = 1'b0;
        be_s        = 4'b0000;
        wdata_rep_s = 32'h0000_0000;
      end
    endcase
  end

  assign lane_s = mem_rdata >> {addr_r[1:0], 3'b000};

  // Load result: addressed lane at bit 0, then sign or zero extension.
  always_comb begin
    ld_data_s = lane_s;
    case (funct3_r)
      3'b000:  ld_data_s = {{24{lane_s[7]}}, lane_s[7:0]};
      3'b001:  ld_data_s = {{16{lane_s[15]}}, lane_s[15:0]};
      3'b100:  ld_data_s = {24'h00_0000, lane_s[7:0]};
      3'b101:  ld_data_s = {16'h0000, lane_s[15:0]};
      default: ld_data_s = lane_s;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  // Cycles spent in MREQ/MWAIT for the current transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 32'd0;
    end else if (state_r == S_CHECK) begin
      tmo_cnt_r <= 32'd0;
    end else if ((state_r == S_MREQ) || (state_r == S_MWAIT)) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // The abort wins over a gnt/rvalid arriving in the final allowed cycle.
  assign tmo_hit_s = (tmo_cnt_r >= 32'(TIMEOUT_CYC - 1));
`else
  logic [31:0] tmo_unused_s;
  assign tmo_unused_s = 32'(TIMEOUT_CYC);
  assign tmo_hit_s    = 1'b0;
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'b0000;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_r) begin
            we_r        <= req_we;
            funct3_r    <= req_funct3;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            state_r     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (legal_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= we_r;
            mem_be_r    <= be_s;
            mem_addr_r  <= {addr_r[31:2], 2'b00};
            mem_wdata_r <= wdata_rep_s;
            state_r     <= S_MREQ;
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= 32'h0000_0000;
            state_r     <= S_RESP;
          end
        end
        S_MREQ: begin
          if (tmo_hit_s) begin
            mem_req_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= 32'h0000_0000;
            state_r     <= S_RESP;
          end else if (mem_gnt) begin
            mem_req_r <= 1'b0;
            state_r   <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (tmo_hit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= 32'h0000_0000;
            state_r     <= S_RESP;
          end else if (mem_rvalid) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= we_r ? 32'h0000_0000 : ld_data_s;
            state_r     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          mem_req_r   <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
